// File: rtl/pcs_8b10b_pkg.sv
// Shared 8b/10b PCS definitions: code-group byte values, xmit modes and
// transmit sequencer states, used by the TX sequencer and the encoder.
package pcs_8b10b_pkg;

    localparam logic [7:0] K28_5 = 8'hBC;
    localparam logic [7:0] K27_7 = 8'hFB;  // /S/
    localparam logic [7:0] K29_7 = 8'hFD;  // /T/
    localparam logic [7:0] K23_7 = 8'hF7;  // /R/
    localparam logic [7:0] K30_7 = 8'hFE;  // /V/
    localparam logic [7:0] D5_6  = 8'hC5;
    localparam logic [7:0] D16_2 = 8'h50;
    localparam logic [7:0] D21_5 = 8'hB5;
    localparam logic [7:0] D2_2  = 8'h42;

    typedef enum logic [1:0] {
        XMIT_IDLE   = 2'd0,
        XMIT_CONFIG = 2'd1,
        XMIT_DATA   = 2'd2,
        XMIT_RSVD   = 2'd3
    } xmit_e;

    typedef enum logic [3:0] {
        IDLE_K, IDLE_D, CFG_K, CFG_D, CFG_LO, CFG_HI,
        SOP, DATA, EOP_T, EOP_R1, EOP_R2, DROP
    } tx_state_e;

    // The reserved encoding behaves exactly like IDLE.
    function automatic xmit_e xmit_norm(input logic [1:0] x);
        return (x == 2'd3) ? XMIT_IDLE : xmit_e'(x);
    endfunction

endpackage

// File: rtl/pcs_tx_ordered_set_gen_if.sv
// GMII transmit side plus encoder-facing outputs of the PCS TX sequencer.
// master drives GMII/config/disparity, slave is the sequencer.
interface pcs_tx_ordered_set_gen_if;
    logic [1:0]  xmit;
    logic [15:0] cfg_reg;
    logic [7:0]  txd;
    logic        tx_en;
    logic        tx_er;
    logic        rd_in;
    logic        enc_enable;
    logic [7:0]  enc_data;
    logic        enc_is_k;
    logic        tx_even;
    logic        frame_active;
    logic        ipg_err;

    modport master (
        output xmit, cfg_reg, txd, tx_en, tx_er, rd_in,
        input  enc_enable, enc_data, enc_is_k, tx_even, frame_active, ipg_err
    );

    modport slave (
        input  xmit, cfg_reg, txd, tx_en, tx_er, rd_in,
        output enc_enable, enc_data, enc_is_k, tx_even, frame_active, ipg_err
    );
endinterface

// File: rtl/pcs_tx_ordered_set_gen.sv
// PCS TX sequencer: idle/config ordered sets, frame delimiters, one code-group per clk.
// Latency: GMII byte to enc_data is 1 cycle (even-slot start) or 2 (odd-slot start).
// Backpressure: none; the encoder consumes every cycle, dropped frames pulse ipg_err.
module pcs_tx_ordered_set_gen
    import pcs_8b10b_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst_n,
    pcs_tx_ordered_set_gen_if.slave  bus
);

    tx_state_e   r_state;
    xmit_e       r_mode;
    logic        r_cset;
    logic [15:0] r_cfg;
    logic        r_lat2;
    logic        r_drop;
    logic [7:0]  r_dly_dat;
    logic        r_dly_en;
    logic        r_dly_er;
    logic        r_enc_enable;
    logic [7:0]  r_enc_data;
    logic        r_enc_is_k;
    logic        r_tx_even;
    logic        r_frame_active;
    logic        r_ipg_err;

    xmit_e       w_xmit;
    logic        w_slot_even;
    logic        w_boundary;
    logic        w_src_en;
    logic        w_src_er;
    logic [7:0]  w_src_dat;
    logic        w_rise;
    logic        w_drop_hit;
    logic [7:0]  w_idle_d;

    assign w_xmit      = xmit_norm(bus.xmit);
    assign w_slot_even = ~r_tx_even;
    assign w_src_en    = r_lat2 ? r_dly_en  : bus.tx_en;
    assign w_src_er    = r_lat2 ? r_dly_er  : bus.tx_er;
    assign w_src_dat   = r_lat2 ? r_dly_dat : bus.txd;
    assign w_rise      = bus.tx_en & ~r_dly_en;
    assign w_idle_d    = bus.rd_in ? D5_6 : D16_2;

    // r_state names the code-group currently on the outputs; an even slot
    // following a completed set or frame end is where xmit is re-sampled.
    always_comb begin
        w_boundary = w_slot_even &&
                     (r_state inside {IDLE_K, IDLE_D, CFG_HI, EOP_R1, EOP_R2, DROP});
        w_drop_hit = w_rise &&
                     ((((r_state == SOP) || (r_state == DATA)) && !w_src_en) ||
                      (r_state == EOP_T) ||
                      ((r_state == EOP_R1) && !w_slot_even));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= IDLE_K;
            r_mode         <= XMIT_IDLE;
            r_cset         <= 1'b0;
            r_cfg          <= 16'h0000;
            r_lat2         <= 1'b0;
            r_drop         <= 1'b0;
            r_dly_dat      <= 8'h00;
            r_dly_en       <= 1'b0;
            r_dly_er       <= 1'b0;
            r_enc_enable   <= 1'b0;
            r_enc_data     <= 8'h00;
            r_enc_is_k     <= 1'b0;
            r_tx_even      <= 1'b0;
            r_frame_active <= 1'b0;
            r_ipg_err      <= 1'b0;
        end else begin
            r_enc_enable <= 1'b1;
            r_tx_even    <= w_slot_even;
            r_dly_dat    <= bus.txd;
            r_dly_en     <= bus.tx_en;
            r_dly_er     <= bus.tx_er;
            r_ipg_err    <= w_drop_hit;
            r_drop       <= bus.tx_en & (r_drop | w_drop_hit);

            if (w_boundary) begin
                r_mode         <= w_xmit;
                r_enc_is_k     <= 1'b1;
                r_enc_data     <= K28_5;
                r_frame_active <= 1'b0;
                if (r_lat2) begin
                    r_mode         <= XMIT_DATA;
                    r_enc_data     <= K27_7;
                    r_frame_active <= 1'b1;
                    r_state        <= SOP;
                end else if (w_xmit == XMIT_CONFIG) begin
                    r_cfg   <= bus.cfg_reg;
                    r_state <= CFG_K;
                end else if ((w_xmit == XMIT_DATA) && bus.tx_en && !r_drop) begin
                    r_enc_data     <= K27_7;
                    r_frame_active <= 1'b1;
                    r_state        <= SOP;
                end else if ((w_xmit == XMIT_DATA) && bus.tx_en) begin
                    r_state <= DROP;
                end else begin
                    r_state <= IDLE_K;
                end
            end else begin
                case (r_state)
                    IDLE_K, DROP: begin
                        r_enc_data     <= w_idle_d;
                        r_enc_is_k     <= 1'b0;
                        r_frame_active <= 1'b0;
                        r_state        <= (r_state == DROP) ? DROP : IDLE_D;
                        // Start seen on an odd slot: /S/ goes out next, fed from the delay stage.
                        if ((r_state == IDLE_K) && (r_mode == XMIT_DATA) && bus.tx_en && !r_drop)
                            r_lat2 <= 1'b1;
                    end
                    CFG_K: begin
                        r_enc_data <= r_cset ? D2_2 : D21_5;
                        r_enc_is_k <= 1'b0;
                        r_state    <= CFG_D;
                    end
                    CFG_D: begin
                        r_enc_data <= r_cfg[7:0];
                        r_enc_is_k <= 1'b0;
                        r_state    <= CFG_LO;
                    end
                    CFG_LO: begin
                        r_enc_data <= r_cfg[15:8];
                        r_enc_is_k <= 1'b0;
                        r_cset     <= ~r_cset;
                        r_state    <= CFG_HI;
                    end
                    SOP, DATA: begin
                        r_frame_active <= 1'b1;
                        if (w_src_en) begin
                            r_enc_data <= w_src_er ? K30_7 : w_src_dat;
                            r_enc_is_k <= w_src_er;
                            r_state    <= DATA;
                        end else begin
                            r_enc_data <= K29_7;
                            r_enc_is_k <= 1'b1;
                            r_lat2     <= 1'b0;
                            r_state    <= EOP_T;
                        end
                    end
                    EOP_T, EOP_R1: begin
                        r_enc_data     <= K23_7;
                        r_enc_is_k     <= 1'b1;
                        r_frame_active <= 1'b0;
                        r_state        <= (r_state == EOP_T) ? EOP_R1 : EOP_R2;
                    end
                    default: begin
                        r_enc_data     <= K28_5;
                        r_enc_is_k     <= 1'b1;
                        r_frame_active <= 1'b0;
                        r_state        <= IDLE_K;
                    end
                endcase
            end
        end
    end

    assign bus.enc_enable   = r_enc_enable;
    assign bus.enc_data     = r_enc_data;
    assign bus.enc_is_k     = r_enc_is_k;
    assign bus.tx_even      = r_tx_even;
    assign bus.frame_active = r_frame_active;
    assign bus.ipg_err      = r_ipg_err;

endmodule

// File: tb/tb_pcs_tx_ordered_set_gen.sv
// Directed bench for the PCS TX sequencer: idle, config, frames at both
// alignments, /V/ insertion, IPG drop and mid-frame reset.
module tb_pcs_tx_ordered_set_gen;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_pass;

    pcs_tx_ordered_set_gen_if bus ();

    pcs_tx_ordered_set_gen dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (bus.enc_enable !== 1'b0) $display("FAIL rst_enable got %b want 0", bus.enc_enable); else n_pass++;
        n_checks++; if (bus.enc_data !== 8'h00) $display("FAIL rst_data got %h want 00", bus.enc_data); else n_pass++;
        n_checks++; if (bus.enc_is_k !== 1'b0) $display("FAIL rst_is_k got %b want 0", bus.enc_is_k); else n_pass++;
        n_checks++; if (bus.tx_even !== 1'b0) $display("FAIL rst_tx_even got %b want 0", bus.tx_even); else n_pass++;
        n_checks++; if (bus.frame_active !== 1'b0) $display("FAIL rst_frame_active got %b want 0", bus.frame_active); else n_pass++;
        n_checks++; if (bus.ipg_err !== 1'b0) $display("FAIL rst_ipg_err got %b want 0", bus.ipg_err); else n_pass++;
        rst_n = 1'b1;
        tick();
        n_checks++; if (bus.enc_enable !== 1'b1) $display("FAIL first_enable got %b want 1", bus.enc_enable); else n_pass++;
        n_checks++; if (bus.enc_data !== 8'hBC) $display("FAIL first_data got %h want bc", bus.enc_data); else n_pass++;
        n_checks++; if (bus.tx_even !== 1'b1) $display("FAIL first_tx_even got %b want 1", bus.tx_even); else n_pass++;
    endtask

    task automatic test_idle();
        logic [7:0] exp_d [5];
        logic       ev;
        exp_d = '{8'h50, 8'hBC, 8'h50, 8'hBC, 8'hC5};
        ev = 1'b1;
        for (int i = 0; i < 5; i++) begin
            bus.rd_in = (i == 4);
            tick();
            ev = ~ev;
            n_checks++; if (bus.enc_data !== exp_d[i]) $display("FAIL idle_data[%0d] got %h want %h", i, bus.enc_data, exp_d[i]); else n_pass++;
            n_checks++; if (bus.tx_even !== ev) $display("FAIL idle_even[%0d] got %b want %b", i, bus.tx_even, ev); else n_pass++;
        end
        bus.rd_in = 1'b0;
    endtask

    task automatic test_config();
        logic [7:0] exp_d [10];
        logic       exp_k [10];
        exp_d = '{8'hBC, 8'hB5, 8'hA0, 8'h01, 8'hBC, 8'h42, 8'h44, 8'h33, 8'hBC, 8'h50};
        exp_k = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        bus.xmit = 2'd1;
        for (int i = 0; i < 10; i++) begin
            bus.cfg_reg = (i == 0) ? 16'h01A0 : 16'h3344;
            if (i == 5) bus.xmit = 2'd0;
            tick();
            n_checks++; if (bus.enc_data !== exp_d[i]) $display("FAIL cfg_data[%0d] got %h want %h", i, bus.enc_data, exp_d[i]); else n_pass++;
            n_checks++; if (bus.enc_is_k !== exp_k[i]) $display("FAIL cfg_is_k[%0d] got %b want %b", i, bus.enc_is_k, exp_k[i]); else n_pass++;
        end
    endtask

    task automatic test_frame_even();
        logic       in_en [12];
        logic [7:0] in_d  [12];
        logic [7:0] exp_d [12];
        logic       exp_k [12];
        logic       exp_f [12];
        in_en = '{0, 0, 1, 1, 1, 1, 1, 0, 0, 0, 0, 0};
        in_d  = '{8'h00, 8'h00, 8'h55, 8'h55, 8'hD5, 8'h11, 8'h22, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        exp_d = '{8'hBC, 8'h50, 8'hFB, 8'h55, 8'hD5, 8'h11, 8'h22, 8'hFD, 8'hF7, 8'hF7, 8'hBC, 8'h50};
        exp_k = '{1, 0, 1, 0, 0, 0, 0, 1, 1, 1, 1, 0};
        exp_f = '{0, 0, 1, 1, 1, 1, 1, 1, 0, 0, 0, 0};
        bus.xmit = 2'd2;
        for (int i = 0; i < 12; i++) begin
            bus.tx_en = in_en[i];
            bus.txd   = in_d[i];
            tick();
            n_checks++; if (bus.enc_data !== exp_d[i]) $display("FAIL feven_data[%0d] got %h want %h", i, bus.enc_data, exp_d[i]); else n_pass++;
            n_checks++; if (bus.enc_is_k !== exp_k[i]) $display("FAIL feven_is_k[%0d] got %b want %b", i, bus.enc_is_k, exp_k[i]); else n_pass++;
            n_checks++; if (bus.frame_active !== exp_f[i]) $display("FAIL feven_active[%0d] got %b want %b", i, bus.frame_active, exp_f[i]); else n_pass++;
        end
    endtask

    task automatic test_frame_odd();
        logic       in_en [12];
        logic [7:0] in_d  [12];
        logic [7:0] exp_d [12];
        logic       exp_f [12];
        logic       ev;
        in_en = '{0, 1, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0};
        in_d  = '{8'h00, 8'h55, 8'h55, 8'hD5, 8'h11, 8'h22, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        exp_d = '{8'hBC, 8'h50, 8'hFB, 8'h55, 8'hD5, 8'h11, 8'h22, 8'hFD, 8'hF7, 8'hF7, 8'hBC, 8'h50};
        exp_f = '{0, 0, 1, 1, 1, 1, 1, 1, 0, 0, 0, 0};
        ev = 1'b0;
        for (int i = 0; i < 12; i++) begin
            bus.tx_en = in_en[i];
            bus.txd   = in_d[i];
            tick();
            ev = ~ev;
            n_checks++; if (bus.enc_data !== exp_d[i]) $display("FAIL fodd_data[%0d] got %h want %h", i, bus.enc_data, exp_d[i]); else n_pass++;
            n_checks++; if (bus.frame_active !== exp_f[i]) $display("FAIL fodd_active[%0d] got %b want %b", i, bus.frame_active, exp_f[i]); else n_pass++;
            n_checks++; if (bus.tx_even !== ev) $display("FAIL fodd_even[%0d] got %b want %b", i, bus.tx_even, ev); else n_pass++;
        end
    endtask

    task automatic test_tx_error();
        logic       in_en [10];
        logic [7:0] in_d  [10];
        logic [7:0] exp_d [10];
        logic       exp_k [10];
        in_en = '{0, 0, 1, 1, 1, 1, 0, 0, 0, 0};
        in_d  = '{8'h00, 8'h00, 8'h55, 8'h55, 8'hD5, 8'h11, 8'h00, 8'h00, 8'h00, 8'h00};
        exp_d = '{8'hBC, 8'h50, 8'hFB, 8'h55, 8'hD5, 8'hFE, 8'hFD, 8'hF7, 8'hBC, 8'h50};
        exp_k = '{1, 0, 1, 0, 0, 1, 1, 1, 1, 0};
        for (int i = 0; i < 10; i++) begin
            bus.tx_en = in_en[i];
            bus.txd   = in_d[i];
            bus.tx_er = (i == 5);
            tick();
            n_checks++; if (bus.enc_data !== exp_d[i]) $display("FAIL txer_data[%0d] got %h want %h", i, bus.enc_data, exp_d[i]); else n_pass++;
            n_checks++; if (bus.enc_is_k !== exp_k[i]) $display("FAIL txer_is_k[%0d] got %b want %b", i, bus.enc_is_k, exp_k[i]); else n_pass++;
        end
        bus.tx_er = 1'b0;
    endtask

    task automatic test_ipg_drop();
        logic       in_en [11];
        logic [7:0] exp_d [11];
        logic       exp_f [11];
        logic       exp_e [11];
        in_en = '{0, 0, 1, 1, 0, 1, 1, 1, 1, 0, 0};
        exp_d = '{8'hBC, 8'h50, 8'hFB, 8'h55, 8'hFD, 8'hF7, 8'hBC, 8'h50, 8'hBC, 8'h50, 8'hBC};
        exp_f = '{0, 0, 1, 1, 1, 0, 0, 0, 0, 0, 0};
        exp_e = '{0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0};
        for (int i = 0; i < 11; i++) begin
            bus.tx_en = in_en[i];
            bus.txd   = in_en[i] ? 8'h55 : 8'h00;
            tick();
            n_checks++; if (bus.enc_data !== exp_d[i]) $display("FAIL drop_data[%0d] got %h want %h", i, bus.enc_data, exp_d[i]); else n_pass++;
            n_checks++; if (bus.frame_active !== exp_f[i]) $display("FAIL drop_active[%0d] got %b want %b", i, bus.frame_active, exp_f[i]); else n_pass++;
            n_checks++; if (bus.ipg_err !== exp_e[i]) $display("FAIL drop_ipg_err[%0d] got %b want %b", i, bus.ipg_err, exp_e[i]); else n_pass++;
        end
    endtask

    task automatic test_reset_midframe();
        bus.tx_en = 1'b0;
        tick();
        bus.tx_en = 1'b1;
        bus.txd   = 8'h55;
        tick();
        n_checks++; if (bus.enc_data !== 8'hFB) $display("FAIL mid_sop got %h want fb", bus.enc_data); else n_pass++;
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++; if (bus.enc_enable !== 1'b0) $display("FAIL mid_rst_enable got %b want 0", bus.enc_enable); else n_pass++;
        n_checks++; if (bus.enc_data !== 8'h00) $display("FAIL mid_rst_data got %h want 00", bus.enc_data); else n_pass++;
        n_checks++; if (bus.enc_is_k !== 1'b0) $display("FAIL mid_rst_is_k got %b want 0", bus.enc_is_k); else n_pass++;
        n_checks++; if (bus.tx_even !== 1'b0) $display("FAIL mid_rst_even got %b want 0", bus.tx_even); else n_pass++;
        n_checks++; if (bus.frame_active !== 1'b0) $display("FAIL mid_rst_active got %b want 0", bus.frame_active); else n_pass++;
        n_checks++; if (bus.ipg_err !== 1'b0) $display("FAIL mid_rst_ipg_err got %b want 0", bus.ipg_err); else n_pass++;
        tick();
        n_checks++; if (bus.enc_enable !== 1'b0) $display("FAIL mid_rst_hold got %b want 0", bus.enc_enable); else n_pass++;
        bus.tx_en = 1'b0;
        rst_n = 1'b1;
        tick();
        n_checks++; if (bus.enc_data !== 8'hBC) $display("FAIL mid_restart_data got %h want bc", bus.enc_data); else n_pass++;
        n_checks++; if (bus.tx_even !== 1'b1) $display("FAIL mid_restart_even got %b want 1", bus.tx_even); else n_pass++;
        n_checks++; if (bus.frame_active !== 1'b0) $display("FAIL mid_restart_active got %b want 0", bus.frame_active); else n_pass++;
    endtask

    initial begin
        n_checks    = 0;
        n_pass      = 0;
        rst_n       = 1'b0;
        bus.xmit    = 2'd0;
        bus.cfg_reg = 16'h0000;
        bus.txd     = 8'h00;
        bus.tx_en   = 1'b0;
        bus.tx_er   = 1'b0;
        bus.rd_in   = 1'b0;
        test_reset();
        test_idle();
        test_config();
        test_frame_even();
        test_frame_odd();
        test_tx_error();
        test_ipg_drop();
        test_reset_midframe();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/pcs_tx_ordered_set_gen.md
# pcs_tx_ordered_set_gen

Clause 36 PCS transmit sequencer. It sits between the GMII transmit interface and `encoder_8b10b`, and drives that encoder one code-group per clock. It generates the following, while keeping ordered sets aligned to even code-group positions:
- idle ordered sets /I1/ and /I2/, chosen by running disparity;
- configuration ordered sets /C1/ and /C2/;
- frame delimiters /S/, /T/ and /R/;
- error propagation /V/.

## Interface
Parameters: none.

Ports:
- clk  in  1  PCS transmit clock, one code-group per cycle.
- rst_n  in  1  asynchronous, active-low reset.
- xmit  in  2  transmit mode: 0 = IDLE, 1 = CONFIG, 2 = DATA, 3 = treated as IDLE.
- cfg_reg  in  16  autonegotiation config register for /C/ sets.
- txd  in  8  GMII transmit data.
- tx_en  in  1  GMII transmit enable.
- tx_er  in  1  GMII transmit error.
- rd_in  in  1  encoder running-disparity register (1 = RD+). This is the value before the currently presented code-group is encoded.
- enc_enable  out  1  encoder enable.
- enc_data  out  8  encoder `data_in`.
- enc_is_k  out  1  encoder `is_control`.
- tx_even  out  1  current output code-group occupies an even position.
- frame_active  out  1  output is between /S/ and /T/ inclusive.
- ipg_err  out  1  one-cycle pulse when a frame is dropped.

## Operation
- All outputs are registered. The encoder consumes the output at the next edge.
- Constants:
  - K28.5 = BC
  - /S/ K27.7 = FB
  - /T/ K29.7 = FD
  - /R/ K23.7 = F7
  - /V/ K30.7 = FE
  - D5.6 = C5
  - D16.2 = 50
  - D21.5 = B5
  - D2.2 = 42
- Ordered-set position alternates even/odd every cycle. A new ordered set always starts on an even slot.
- Idle set: K28.5 on the even slot, then the odd slot.
  - Odd slot carries D5.6 (/I1/) if rd_in = 1 when it is registered, else D16.2 (/I2/).
  - At that edge, rd_in equals the disparity before K28.5.
- CONFIG: 4-group sets, alternating C1 then C2, starting with C1.
  - C1 = K28.5, D21.5, cfg_reg[7:0], cfg_reg[15:8].
  - C2 = K28.5, D2.2, cfg_reg[7:0], cfg_reg[15:8].
  - cfg_reg is captured once, when K28.5 is registered.
- xmit is sampled only at ordered-set boundaries: an even slot, with no C set or frame in progress.
  - If xmit leaves DATA mid-frame, the frame completes normally first.
- DATA frame start (only in DATA mode, at the first sampled cycle with tx_en = 1):
  - If the slot being registered is even, emit /S/ in place of that byte (latency L = 1).
  - If it is odd, finish the idle's odd group, then emit /S/ next cycle (L = 2).
  - Input passes through a one-stage delay register. L is frozen for the whole frame.
- In frame, each byte is sent as D(txd), with enc_is_k = 0. If tx_er = 1 for that byte, /V/ is sent instead.
- Frame end: the first delayed byte with tx_en = 0 is replaced by /T/, followed by /R/.
  - If that /R/ sits on an even slot, a second /R/ follows.
  - Idle therefore always resumes on an even slot.
- tx_en rise while /T/ or /R/ is still pending:
  - Frame is dropped; idles continue until tx_en falls.
  - ipg_err pulses for 1 cycle.
- FSM states: IDLE_K, IDLE_D, CFG_K, CFG_D, CFG_LO, CFG_HI, SOP, DATA, EOP_T, EOP_R1, EOP_R2, DROP.

## Timing
- Reset values:
  - enc_enable = 0, enc_data = 00, enc_is_k = 0, tx_even = 0, frame_active = 0, ipg_err = 0.
  - State is IDLE_K; C-set toggle selects C1.
- First edge after reset: enc_enable = 1 (held from then on), K28.5 with tx_even = 1.
- The first ordered set after reset follows xmit as sampled at that edge.
- Reset mid-frame: outputs return to reset values immediately; the frame is not terminated.
- Data latency: a GMII byte sampled at edge E appears on enc_data after edge E + L − 1.

## Structure
- Package `pcs_8b10b_pkg` holds:
  - all code-group constants above;
  - the xmit enum;
  - the FSM state enum.
- `encoder_8b10b` is shared by this block and the future receive checker, and imports the package.
- Single module; no sub-module. The delay stage and FSM are both inline. The encoder is instantiated by the parent PCS top.

## Test plan
- Reset release, xmit = IDLE, rd_in = 0 → BC, 50 repeating; tx_even toggles starting at 1. With rd_in = 1 on the odd slot → C5.
- xmit = CONFIG, cfg_reg = 01A0 → BC, B5, A0, 01, BC, 42, A0, 01. A cfg_reg change mid-set takes effect only at the next BC.
- DATA, tx_en rises on an even slot with bytes 55, 55, D5, 11, 22 → FB, 55, D5, 11, 22, FD, F7, with a second F7 only if needed for alignment.
- DATA, tx_en rises on an odd slot → idle odd group, then FB. Frame shifted by 1 cycle (L = 2). End sequence realigns idle to an even slot.
- tx_er = 1 on the third in-frame byte → FE at that position; other bytes unchanged.
- tx_en re-asserts 1 cycle after falling → ipg_err pulses, frame dropped, idles continue. Also: asserting rst_n low mid-frame forces all outputs to reset values.
